// File: rtl/fft_stage_ctrl.sv
// Stage/pair sequencer for one radix-2 DIF butterfly running an in-place FFT.
// Optional abort input is enabled by defining FFT_CTRL_ABORT_EN.
module fft_stage_ctrl #(
  parameter int POINTS     = 16,
  parameter int ADDR_W     = 4,
  parameter int BF_LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
`ifdef FFT_CTRL_ABORT_EN
  input  logic                     abort,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(ADDR_W):0]  stage,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr_a,
  output logic [ADDR_W-1:0]        rd_addr_b,
  output logic                     bf_en,
  output logic [ADDR_W-2:0]        tw_idx,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr_a,
  output logic [ADDR_W-1:0]        wr_addr_b
);

  localparam int DEPTH = BF_LATENCY + 1;
  localparam int PAIRS = POINTS / 2;
  localparam int SW    = $clog2(ADDR_W) + 1;
  localparam int PW    = ADDR_W - 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam logic [SW-1:0] LAST_S = SW'(ADDR_W - 1);
  localparam logic [PW-1:0] LAST_P = PW'(PAIRS - 1);
  localparam logic [CW-1:0] LAST_D = CW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state;
  logic [PW-1:0]     p;
  logic [CW-1:0]     drain_cnt;
  logic              issue_v;
  logic [PW-1:0]     issue_tw;
  logic              abort_hit;

  logic [SW-1:0]     cand_s;
  logic [PW-1:0]     cand_p;
  logic [ADDR_W-1:0] cand_a;
  logic [ADDR_W-1:0] cand_b;
  logic [PW-1:0]     cand_tw;

  logic [DEPTH-1:0]  dl_v;
  logic [ADDR_W-1:0] dl_a [DEPTH];
  logic [ADDR_W-1:0] dl_b [DEPTH];

  function automatic logic [ADDR_W-1:0] span_of(input logic [SW-1:0] st);
    return ADDR_W'(POINTS >> (st + 1'b1));
  endfunction

  // Pair p of a stage sits in block p/span; the block base is doubled because
  // each block holds 2*span points, the offset within it is p%span.
  function automatic logic [ADDR_W-1:0] addr_a_of(input logic [SW-1:0] st,
                                                  input logic [PW-1:0] pr);
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] pe;
    mask = span_of(st) - ADDR_W'(1);
    pe   = {1'b0, pr};
    return ((pe & ~mask) << 1) | (pe & mask);
  endfunction

  function automatic logic [PW-1:0] tw_of(input logic [SW-1:0] st,
                                         input logic [PW-1:0] pr);
    logic [PW-1:0] low;
    low = pr & PW'(span_of(st) - ADDR_W'(1));
    return low << st;
  endfunction

`ifdef FFT_CTRL_ABORT_EN
  assign abort_hit = abort && (state == ISSUE || state == DRAIN);
`else
  assign abort_hit = 1'b0;
`endif

  // The pair that will be presented on the read port after the next edge.
  always_comb begin
    cand_s = stage;
    cand_p = p + 1'b1;
    if (state == IDLE) begin
      cand_s = '0;
      cand_p = '0;
    end else if (state == DRAIN) begin
      cand_s = stage + 1'b1;
      cand_p = '0;
    end
    cand_a  = addr_a_of(cand_s, cand_p);
    cand_b  = cand_a + span_of(cand_s);
    cand_tw = tw_of(cand_s, cand_p);
  end

  // Handshake: start is a request sampled only in IDLE; busy acknowledges it
  // from the next cycle and stays high until the cycle done pulses once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stage     <= '0;
      p         <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      issue_v   <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      issue_tw  <= '0;
    end else begin
      done <= 1'b0;
      if (abort_hit) begin
        state     <= IDLE;
        stage     <= '0;
        p         <= '0;
        drain_cnt <= '0;
        busy      <= 1'b0;
        issue_v   <= 1'b0;
        rd_addr_a <= '0;
        rd_addr_b <= '0;
        issue_tw  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= ISSUE;
              busy      <= 1'b1;
              stage     <= '0;
              p         <= '0;
              issue_v   <= 1'b1;
              rd_addr_a <= cand_a;
              rd_addr_b <= cand_b;
              issue_tw  <= cand_tw;
            end
          end
          ISSUE: begin
            if (p == LAST_P) begin
              state     <= DRAIN;
              drain_cnt <= '0;
              issue_v   <= 1'b0;
              rd_addr_a <= '0;
              rd_addr_b <= '0;
              issue_tw  <= '0;
            end else begin
              p         <= cand_p;
              rd_addr_a <= cand_a;
              rd_addr_b <= cand_b;
              issue_tw  <= cand_tw;
            end
          end
          DRAIN: begin
            // Leave on the cycle the stage's final write-back is on the port,
            // so the next stage's first read follows its last write.
            if (drain_cnt == LAST_D) begin
              if (stage == LAST_S) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state     <= ISSUE;
                stage     <= cand_s;
                p         <= '0;
                issue_v   <= 1'b1;
                rd_addr_a <= cand_a;
                rd_addr_b <= cand_b;
                issue_tw  <= cand_tw;
              end
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            stage <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_v   <= '0;
      tw_idx <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dl_a[i] <= '0;
        dl_b[i] <= '0;
      end
    end else if (abort_hit) begin
      dl_v   <= '0;
      tw_idx <= '0;
    end else begin
      dl_v[0] <= issue_v;
      dl_a[0] <= rd_addr_a;
      dl_b[0] <= rd_addr_b;
      tw_idx  <= issue_tw;
      for (int i = 1; i < DEPTH; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_a[i] <= dl_a[i-1];
        dl_b[i] <= dl_b[i-1];
      end
    end
  end

  assign rd_en     = issue_v & ~abort_hit;
  assign bf_en     = dl_v[0];
  assign wr_en     = dl_v[DEPTH-1] & ~abort_hit;
  assign wr_addr_a = dl_a[DEPTH-1];
  assign wr_addr_b = dl_b[DEPTH-1];

  a_stage_starts_empty: assert property (@(posedge clk) disable iff (!rst_n)
    (issue_v && p == '0) |-> (dl_v == '0));

  a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: a 16-point default instance and an 8-point instance
// (BF_LATENCY=2), checked against hand-written pair/twiddle tables.
module tb_fft_stage_ctrl;

  localparam int W = 32;
  localparam logic [1:0] K_RD = 2'd0, K_BF = 2'd1, K_WR = 2'd2, K_DN = 2'd3;

  logic clk = 1'b0;
  logic rst_n, start0, start1;
  logic abort0, abort1;

  logic       busy0, done0, rd_en0, bf_en0, wr_en0;
  logic [2:0] stage0, tw0;
  logic [3:0] ra0, rb0, wa0, wb0;

  logic       busy1, done1, rd_en1, bf_en1, wr_en1;
  logic [2:0] stage1;
  logic [1:0] tw1;
  logic [2:0] ra1, rb1, wa1, wb1;

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  int act_t0 [2]    = '{-100, -100};
  int act_end [2]   = '{0, 0};
  int idle_from [2] = '{0, 0};
  int wr_cnt [2]    = '{0, 0};

  // Hand-computed rd_addr_a and twiddle per (stage, pair); rd_addr_b = a + span.
  int a16 [4][8] = '{'{0,1,2,3,4,5,6,7}, '{0,1,2,3,8,9,10,11},
                     '{0,1,4,5,8,9,12,13}, '{0,2,4,6,8,10,12,14}};
  int t16 [4][8] = '{'{0,1,2,3,4,5,6,7}, '{0,2,4,6,0,2,4,6},
                     '{0,4,0,4,0,4,0,4}, '{0,0,0,0,0,0,0,0}};
  int sp16 [4]   = '{8, 4, 2, 1};
  int a8 [3][4]  = '{'{0,1,2,3}, '{0,1,4,5}, '{0,2,4,6}};
  int t8 [3][4]  = '{'{0,1,2,3}, '{0,2,0,2}, '{0,0,0,0}};
  int sp8 [3]    = '{4, 2, 1};

  fft_stage_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
`ifdef FFT_CTRL_ABORT_EN
    .abort(abort0),
`endif
    .busy(busy0), .done(done0), .stage(stage0),
    .rd_en(rd_en0), .rd_addr_a(ra0), .rd_addr_b(rb0),
    .bf_en(bf_en0), .tw_idx(tw0),
    .wr_en(wr_en0), .wr_addr_a(wa0), .wr_addr_b(wb0)
  );

  fft_stage_ctrl #(.POINTS(8), .ADDR_W(3), .BF_LATENCY(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef FFT_CTRL_ABORT_EN
    .abort(abort1),
`endif
    .busy(busy1), .done(done1), .stage(stage1),
    .rd_en(rd_en1), .rd_addr_a(ra1), .rd_addr_b(rb1),
    .bf_en(bf_en1), .tw_idx(tw1),
    .wr_en(wr_en1), .wr_addr_a(wa1), .wr_addr_b(wb1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  task automatic push(input int id, input logic [1:0] kind, input int c, input logic [15:0] pl);
    exp_q.push_back({id[0], kind, 13'(c), pl});
  endtask

  task automatic push_xform(input int id, input int t0);
    int ns, np, per, lag, dlat, a, tw, span, rc;
    ns   = (id == 0) ? 4 : 3;
    np   = (id == 0) ? 8 : 4;
    per  = (id == 0) ? 13 : 7;
    lag  = (id == 0) ? 5 : 3;
    dlat = (id == 0) ? 53 : 22;
    for (int s = 0; s < ns; s++) begin
      for (int p = 0; p < np; p++) begin
        if (id == 0) begin
          a = a16[s][p]; tw = t16[s][p]; span = sp16[s];
        end else begin
          a = a8[s][p]; tw = t8[s][p]; span = sp8[s];
        end
        rc = t0 + 1 + s * per + p;
        push(id, K_RD, rc, {5'd0, 3'(s), 4'(a), 4'(a + span)});
        push(id, K_BF, rc + 1, {13'd0, 3'(tw)});
        push(id, K_WR, rc + lag, {8'd0, 4'(a), 4'(a + span)});
      end
    end
    push(id, K_DN, t0 + dlat, 16'd0);
  endtask

  task automatic check_evt(input int id, input logic [1:0] kind, input logic [15:0] got,
                           input string what);
    int hit;
    logic [W-1:0] e;
    hit = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (hit < 0 && exp_q[i][31:29] == {id[0], kind}) hit = i;
    n_checks++;
    if (hit < 0) begin
      n_err++;
      $display("FAIL %s dut%0d: unexpected at cycle %0d data %h, none expected", what, id, cyc, got);
    end else begin
      e = exp_q[hit];
      exp_q.delete(hit);
      if (e[28:16] != 13'(cyc) || e[15:0] != got) begin
        n_err++;
        $display("FAIL %s dut%0d: got cycle %0d data %h, expected cycle %0d data %h",
                 what, id, cyc, got, e[28:16], e[15:0]);
      end
    end
  endtask

  task automatic check_val(input string what, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", what, got, want);
    end
  endtask

  task automatic mon(input int id, input logic rd, input logic [3:0] ra, input logic [3:0] rb,
                     input logic [2:0] st, input logic bf, input logic [2:0] tw,
                     input logic wr, input logic [3:0] wa, input logic [3:0] wb,
                     input logic dn, input logic bsy);
    logic bexp;
    if (rd) check_evt(id, K_RD, {5'd0, st, ra, rb}, "read");
    if (bf) check_evt(id, K_BF, {13'd0, tw}, "twiddle");
    if (wr) begin
      wr_cnt[id]++;
      check_evt(id, K_WR, {8'd0, wa, wb}, "write");
    end
    if (dn) begin
      check_evt(id, K_DN, 16'd0, "done");
      check_val($sformatf("write_count dut%0d", id), wr_cnt[id], (id == 0) ? 32 : 12);
      wr_cnt[id] = 0;
    end
    bexp = (cyc > act_t0[id]) && (cyc < act_end[id]);
    n_checks++;
    if (bsy !== bexp) begin
      n_err++;
      $display("FAIL busy dut%0d cycle %0d: got %b expected %b", id, cyc, bsy, bexp);
    end
  endtask

  // Monitor samples on the falling edge, away from register updates.
  always @(negedge clk) begin
    mon(0, rd_en0, ra0, rb0, stage0, bf_en0, tw0, wr_en0, wa0, wb0, done0, busy0);
    mon(1, rd_en1, {1'b0, ra1}, {1'b0, rb1}, stage1, bf_en1, {1'b0, tw1},
        wr_en1, {1'b0, wa1}, {1'b0, wb1}, done1, busy1);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic accept(input int id, input int t);
    int dlat;
    dlat = (id == 0) ? 53 : 22;
    act_t0[id]    = t;
    act_end[id]   = t + dlat;
    idle_from[id] = t + dlat + 1;
    push_xform(id, t);
  endtask

  task automatic pulse(input bit s0, input bit s1, input int t);
    wait_to(t);
    if (s0) begin
      start0 = 1'b1;
      if (t >= idle_from[0]) accept(0, t);
    end
    if (s1) begin
      start1 = 1'b1;
      if (t >= idle_from[1]) accept(1, t);
    end
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic check_all_zero(input string what);
    n_checks++;
    if ({busy0, done0, stage0, rd_en0, ra0, rb0, bf_en0, tw0, wr_en0, wa0, wb0} !== '0) begin
      n_err++;
      $display("FAIL %s dut0: outputs %h expected 0", what,
               {busy0, done0, stage0, rd_en0, ra0, rb0, bf_en0, tw0, wr_en0, wa0, wb0});
    end
    n_checks++;
    if ({busy1, done1, stage1, rd_en1, ra1, rb1, bf_en1, tw1, wr_en1, wa1, wb1} !== '0) begin
      n_err++;
      $display("FAIL %s dut1: outputs %h expected 0", what,
               {busy1, done1, stage1, rd_en1, ra1, rb1, bf_en1, tw1, wr_en1, wa1, wb1});
    end
  endtask

  task automatic drop_from(input int id, input int c);
    logic [W-1:0] keep_q[$];
    int lim;
    foreach (exp_q[i]) begin
      lim = (exp_q[i][30:29] == K_BF) ? c + 1 : c;
      if (exp_q[i][31] != id[0] || int'(exp_q[i][28:16]) < lim) keep_q.push_back(exp_q[i]);
    end
    exp_q = keep_q;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    abort0 = 1'b0;
    abort1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst_n = 1'b1;

    // Full transforms; repeated starts while busy or in DONE are ignored.
    pulse(1, 1, 10);
    pulse(1, 0, 20);
    pulse(0, 1, 32);
    pulse(0, 1, 33);
    pulse(1, 0, 63);
    pulse(1, 0, 64);

    // Reset 20 cycles into a transform, then a clean transform.
    pulse(1, 0, 130);
    wait_to(150);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      act_end[i]   = cyc;
      idle_from[i] = cyc;
      wr_cnt[i]    = 0;
    end
    wait_to(152);
    rst_n = 1'b1;
    pulse(1, 1, 160);

`ifdef FFT_CTRL_ABORT_EN
    pulse(1, 0, 230);
    wait_to(245);
    abort0 = 1'b1;
    drop_from(0, 245);
    act_end[0]   = 246;
    idle_from[0] = 246;
    wait_to(246);
    abort0    = 1'b0;
    wr_cnt[0] = 0;
    pulse(1, 0, 250);
`endif

    wait_to(320);
    check_val("pending_expectations", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/fft_stage_ctrl.md
# fft_stage_ctrl

Sequencer for a single radix-2 decimation-in-frequency `butterfly` instance running an in-place POINTS-point FFT held in a dual-port synchronous RAM. After `start` it walks every stage and every butterfly pair of that stage, driving RAM read addresses, butterfly enable, twiddle index and RAM write-back addresses. It drains the butterfly pipeline between stages so reads never see stale data. It sits between the sample buffer and the butterfly datapath in the FFT top level.

## Interface
- `POINTS`, 16: FFT length; power of two, ≥4.
- `ADDR_W`, 4: log2(POINTS).
- `BF_LATENCY`, 4: cycles from `bf_en` to valid butterfly output.
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin transform; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse at completion.
- `stage` out log2(ADDR_W)+1: current stage index, 0..ADDR_W-1.
- `rd_en` out 1: RAM read strobe; RAM read latency is 1 cycle.
- `rd_addr_a`, `rd_addr_b` out ADDR_W each: pair read addresses.
- `bf_en` out 1: butterfly enable; this is `rd_en` delayed 1 cycle.
- `tw_idx` out ADDR_W-1: twiddle index, aligned with `bf_en`.
- `wr_en` out 1: RAM write strobe.
- `wr_addr_a`, `wr_addr_b` out ADDR_W each: write-back addresses, aligned with `wr_en`.

## Operation
- FSM states are IDLE, ISSUE, DRAIN and DONE. Reset enters IDLE; every output resets to 0.
- IDLE→ISSUE on `start`=1. Stage counter `s`=0 and pair counter `p`=0.
- ISSUE, one pair per cycle:
  - Outputs: `rd_en`=1, span=POINTS>>(s+1), `rd_addr_a`=(p/span)·2·span + p%span, `rd_addr_b`=`rd_addr_a`+span, twiddle=(p%span)<<s.
  - When `p`=POINTS/2-1 the FSM goes to DRAIN.
- Address/twiddle delay line: depth 1+BF_LATENCY. It carries the addresses to `wr_addr_*` and the twiddle (tapped after 1 stage) to `tw_idx`. It shifts every cycle, including during DRAIN.
- DRAIN: holds until the final pair's `wr_en` cycle.
  - If `s`<ADDR_W-1: `s`++, `p`=0, →ISSUE.
  - Otherwise →DONE.
- DONE: `done`=1 for one cycle, `busy`=0, →IDLE.
- `start` outside IDLE is ignored. Back-to-back `start` in the DONE cycle is ignored; `start` in the following IDLE cycle is accepted.
- `rst_n` low mid-transform: all state and the delay line clear immediately; `wr_en` drops in the same cycle (asynchronously). The RAM holds partial data and is not restored.

## Timing
- `start` accepted at cycle 0. The first `rd_en` is at cycle 1.
- Stage period is POINTS/2 + BF_LATENCY + 1 cycles. Stage k begins at cycle 1+k·period.
- Per pair, `wr_en` occurs 1+BF_LATENCY cycles after its `rd_en`.
- `done` is at cycle 1 + ADDR_W·period. With defaults: period 13, `done` at cycle 53.
- `busy` is high on cycles 1..52 and low in the `done` cycle.
- No read of stage k+1 coincides with an outstanding write of stage k.

## Configuration
- `FFT_CTRL_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - `abort`=1 in ISSUE or DRAIN stops issuing immediately and suppresses all pending `wr_en`.
  - The FSM goes to IDLE next cycle without a `done` pulse; `busy` falls that cycle.
  - `abort` in IDLE or DONE has no effect.
- Undefined: the port is absent and transforms always run to completion.

## Test plan
- Defaults, `start` at cycle 0:
  - Stage 0 reads (0,8),(1,9)…(7,15) with `tw_idx` 0..7.
  - Stage 3 reads (0,1),(2,3)…(14,15) with `tw_idx` 0.
  - `done` at cycle 53 exactly.
- Write-back check: each `wr_addr_a/b` equals the `rd_addr_a/b` issued 5 cycles earlier.
  - 32 writes total, 8 per stage.
  - No read of stage k+1 occurs before the last write of stage k.
- `start` pulsed at cycles 0, 10 and 53 → exactly one transform, no restart. `start` at 54 → second transform, `done` at 107.
- `rst_n` low at cycle 20 → all outputs 0 asynchronously, FSM in IDLE. A new `start` after release gives full timing again (`done` 53 cycles later).
- POINTS=8, BF_LATENCY=2: period 7, `done` at cycle 22; stage 1 reads (0,2),(1,3),(4,6),(5,7) with `tw_idx` 0,2,0,2.
- With `FFT_CTRL_ABORT_EN`, `abort` at cycle 15:
  - No `wr_en` from cycle 15 onward.
  - `busy`=0 at 16, no `done` pulse.
  - A following `start` runs normally.
